// File: rtl/multi_sel_pkg.sv
// Shared definitions for the multi_sel sequencer and its receiver/checker.
// Holds the phase encoding, product multipliers and default widths.
package multi_sel_pkg;

  localparam int DW_DEF = 8;
  localparam int OW_DEF = 11;
  localparam int PHASES = 4;

  localparam int MUL_P0 = 1;
  localparam int MUL_P1 = 3;
  localparam int MUL_P2 = 7;
  localparam int MUL_P3 = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    P3   = 2'd3
  } state_t;

endpackage

// File: rtl/multi_sel_rx_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multi_sel_rx.sv
// Receiver/checker for the d, 3d, 7d, 8d product stream: recovers d,
// checks each product, and counts bad frames and framing faults.
module multi_sel_rx
  import multi_sel_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int OW  = OW_DEF,
  parameter int ECW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_grant,
  input  logic [OW-1:0]  in_data,
  input  logic           err_clr,
  output logic [DW-1:0]  d_out,
  output logic           d_valid,
  output logic [2:0]     prod_err,
  output logic           range_err,
  output logic           sync_err,
  output logic [ECW-1:0] err_cnt
);

  state_t state, state_nxt;

  logic [DW-1:0] d_cap;
  logic          range_flag;
  logic [1:0]    work_err;

  logic          capture;
  logic          sync_hit;
  logic          finish;
  logic [OW-1:0] expected;
  logic          mismatch;
  logic          frame_bad;
  logic          cnt_inc;

  logic [OW-1:0] d_ext;
  logic [OW-1:0] prod3;
  logic [OW-1:0] prod7;
  logic [OW-1:0] prod8;

  assign d_ext = {{(OW-DW){1'b0}}, d_cap};
  assign prod3 = (d_ext << 1) + d_ext;
  assign prod7 = (d_ext << 2) + (d_ext << 1) + d_ext;
  assign prod8 = d_ext << 3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A grant always restarts framing, even in the middle of a frame.
  always_comb begin
    state_nxt = state;
    if (in_grant) begin
      state_nxt = P1;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        P1:      state_nxt = P2;
        P2:      state_nxt = P3;
        P3:      state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    capture  = in_grant;
    sync_hit = in_grant && (state != IDLE);
    finish   = !in_grant && (state == P3);
    case (state)
      P1:      expected = prod3;
      P2:      expected = prod7;
      P3:      expected = prod8;
      default: expected = '0;
    endcase
  end

  assign mismatch  = (in_data != expected);
  assign frame_bad = finish && (mismatch || (|work_err) || range_flag);
  assign cnt_inc   = frame_bad || sync_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_cap      <= '0;
      range_flag <= 1'b0;
      work_err   <= '0;
    end else if (capture) begin
      d_cap      <= in_data[DW-1:0];
      range_flag <= |in_data[OW-1:DW];
      work_err   <= '0;
    end else if (state == P1) begin
      work_err[0] <= mismatch;
    end else if (state == P2) begin
      work_err[1] <= mismatch;
    end
  end

  // The 8d check is folded straight into prod_err on the completing edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out     <= '0;
      d_valid   <= 1'b0;
      prod_err  <= '0;
      range_err <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      d_valid  <= finish;
      sync_err <= sync_hit;
      if (finish) begin
        d_out     <= d_cap;
        prod_err  <= {mismatch, work_err};
        range_err <= range_flag;
      end
    end
  end

  sat_counter #(
    .W(ECW)
  ) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .clr(err_clr),
    .inc(cnt_inc),
    .cnt(err_cnt)
  );

endmodule

// File: tb/tb_multi_sel_rx.sv
// Self-checking bench for multi_sel_rx: directed scenarios plus random frames
// compared against a frame-level reference model.
module tb_multi_sel_rx;

  logic        clk;
  logic        rst;
  logic        in_grant;
  logic [10:0] in_data;
  logic        err_clr;

  logic [7:0]  d_out,    d_out2;
  logic        d_valid,  d_valid2;
  logic [2:0]  prod_err, prod_err2;
  logic        range_err, range_err2;
  logic        sync_err, sync_err2;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt2;

  int errors = 0;
  int checks = 0;

  multi_sel_rx #(.DW(8), .OW(11), .ECW(8)) dut (
    .clk(clk), .rst(rst), .in_grant(in_grant), .in_data(in_data),
    .err_clr(err_clr), .d_out(d_out), .d_valid(d_valid),
    .prod_err(prod_err), .range_err(range_err), .sync_err(sync_err),
    .err_cnt(err_cnt)
  );

  multi_sel_rx #(.DW(8), .OW(11), .ECW(2)) dut2 (
    .clk(clk), .rst(rst), .in_grant(in_grant), .in_data(in_data),
    .err_clr(err_clr), .d_out(d_out2), .d_valid(d_valid2),
    .prod_err(prod_err2), .range_err(range_err2), .sync_err(sync_err2),
    .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: collects the words of the current frame, judges a frame
  // once all four words are in, and keeps both counters with saturation.
  int         m_words [4];
  int         m_nwords;
  logic       m_valid;
  logic [7:0] m_dout;
  logic [2:0] m_prod;
  logic       m_range;
  logic       m_sync;
  logic [7:0] m_cnt8;
  logic [1:0] m_cnt2;

  wire [37:0] obs = {d_valid, d_out, prod_err, range_err, sync_err, err_cnt,
                     d_valid2, d_out2, prod_err2, range_err2, sync_err2, err_cnt2};

  function automatic logic [37:0] exp_bundle();
    return {m_valid, m_dout, m_prod, m_range, m_sync, m_cnt8,
            m_valid, m_dout, m_prod, m_range, m_sync, m_cnt2};
  endfunction

  function automatic void model_reset();
    m_nwords = 0;
    m_valid  = 1'b0;
    m_dout   = '0;
    m_prod   = '0;
    m_range  = 1'b0;
    m_sync   = 1'b0;
    m_cnt8   = '0;
    m_cnt2   = '0;
  endfunction

  function automatic void model_step(input logic g, input int dat, input logic clr);
    int  d;
    logic bump;
    bump    = 1'b0;
    m_valid = 1'b0;
    m_sync  = 1'b0;
    if (g) begin
      if (m_nwords > 0) begin
        m_sync = 1'b1;
        bump   = 1'b1;
      end
      m_words[0] = dat;
      m_nwords   = 1;
    end else if (m_nwords > 0) begin
      m_words[m_nwords] = dat;
      m_nwords++;
      if (m_nwords == 4) begin
        d       = m_words[0] % 256;
        m_dout  = 8'(d);
        m_prod  = {m_words[3] != 8 * d, m_words[2] != 7 * d, m_words[1] != 3 * d};
        m_range = (m_words[0] > 255);
        m_valid = 1'b1;
        if (m_prod != 3'b000 || m_range) bump = 1'b1;
        m_nwords = 0;
      end
    end
    if (clr) begin
      m_cnt8 = '0;
      m_cnt2 = '0;
    end else if (bump) begin
      if (m_cnt8 != 8'hFF) m_cnt8 = m_cnt8 + 8'd1;
      if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
    end
  endfunction

  // Drives one cycle of inputs, advances the model on the edge, and returns
  // 1 time unit after the edge so outputs can be sampled.
  task automatic drive(input logic g, input logic [10:0] dat, input logic clr);
    in_grant = g;
    in_data  = dat;
    err_clr  = clr;
    @(posedge clk);
    model_step(g, int'(dat), clr);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    in_grant = 1'b0;
    in_data  = '0;
    err_clr  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    if (obs !== exp_bundle()) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", obs, exp_bundle());
    end
    checks++;
    rst = 1'b1;
    drive(1'b0, 11'd0, 1'b0);
    if (obs !== exp_bundle()) begin
      errors++;
      $display("[TB] FAIL reset_release: got %h expected %h", obs, exp_bundle());
    end
    checks++;
  endtask

  task automatic test_clean_frame();
    logic [10:0] words [5] = '{11'd5, 11'd15, 11'd35, 11'd40, 11'd0};
    for (int i = 0; i < 5; i++) begin
      drive(i == 0, words[i], 1'b0);
      if (obs !== exp_bundle()) begin
        errors++;
        $display("[TB] FAIL clean_frame cycle %0d: got %h expected %h", i, obs, exp_bundle());
      end
      checks++;
      if (i == 3) begin
        if ({d_valid, d_out, prod_err, range_err, err_cnt} !== {1'b1, 8'h05, 3'b000, 1'b0, 8'd0}) begin
          errors++;
          $display("[TB] FAIL clean_frame_result: got %h expected %h",
                   {d_valid, d_out, prod_err, range_err, err_cnt}, {1'b1, 8'h05, 3'b000, 1'b0, 8'd0});
        end
        checks++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] words [9] = '{11'd255, 11'd765, 11'd1785, 11'd2040,
                               11'd1, 11'd3, 11'd7, 11'd8, 11'd0};
    int first_v;
    int second_v;
    first_v  = -1;
    second_v = -1;
    for (int i = 0; i < 9; i++) begin
      drive(i == 0 || i == 4, words[i], 1'b0);
      if (obs !== exp_bundle()) begin
        errors++;
        $display("[TB] FAIL back_to_back cycle %0d: got %h expected %h", i, obs, exp_bundle());
      end
      checks++;
      if (d_valid === 1'b1) begin
        if (first_v < 0) first_v = i;
        else second_v = i;
      end
    end
    if (second_v - first_v !== 4) begin
      errors++;
      $display("[TB] FAIL back_to_back_spacing: got %0d cycles expected 4", second_v - first_v);
    end
    checks++;
  endtask

  task automatic test_prod_and_range();
    logic [10:0] words [9] = '{11'd0, 11'd10, 11'd30, 11'd71, 11'd80,
                               11'h10A, 11'd30, 11'd70, 11'd80};
    for (int i = 0; i < 9; i++) begin
      drive(i == 1 || i == 5, words[i], i == 0);
      if (obs !== exp_bundle()) begin
        errors++;
        $display("[TB] FAIL prod_and_range cycle %0d: got %h expected %h", i, obs, exp_bundle());
      end
      checks++;
    end
    drive(1'b0, 11'd0, 1'b0);
    if ({range_err, prod_err, err_cnt} !== {1'b1, 3'b000, 8'd2}) begin
      errors++;
      $display("[TB] FAIL range_flag: got %h expected %h", {range_err, prod_err, err_cnt}, {1'b1, 3'b000, 8'd2});
    end
    checks++;
  endtask

  task automatic test_sync_abort();
    logic [10:0] words [8] = '{11'd0, 11'd4, 11'd12, 11'd6, 11'd18, 11'd42, 11'd48, 11'd0};
    logic        grant [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int valid_seen;
    valid_seen = 0;
    for (int i = 0; i < 8; i++) begin
      drive(grant[i], words[i], i == 0);
      if (obs !== exp_bundle()) begin
        errors++;
        $display("[TB] FAIL sync_abort cycle %0d: got %h expected %h", i, obs, exp_bundle());
      end
      checks++;
      if (d_valid === 1'b1) valid_seen++;
    end
    if ({valid_seen[3:0], d_out, prod_err, err_cnt} !== {4'd1, 8'd6, 3'b000, 8'd1}) begin
      errors++;
      $display("[TB] FAIL sync_abort_result: got %h expected %h",
               {valid_seen[3:0], d_out, prod_err, err_cnt}, {4'd1, 8'd6, 3'b000, 8'd1});
    end
    checks++;
  endtask

  task automatic test_saturation();
    logic [10:0] words [4] = '{11'd1, 11'd3, 11'd7, 11'd9};
    drive(1'b0, 11'd0, 1'b1);
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 4; i++) begin
        drive(i == 0, words[i], 1'b0);
        if (obs !== exp_bundle()) begin
          errors++;
          $display("[TB] FAIL saturation frame %0d word %0d: got %h expected %h", f, i, obs, exp_bundle());
        end
        checks++;
      end
    end
    if (err_cnt2 !== 2'd3) begin
      errors++;
      $display("[TB] FAIL saturate_at_max: got %0d expected 3", err_cnt2);
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, words[i], i == 3);
    end
    if ({d_valid, prod_err, err_cnt, err_cnt2} !== {1'b1, 3'b100, 8'd0, 2'd0}) begin
      errors++;
      $display("[TB] FAIL clear_priority: got %h expected %h",
               {d_valid, prod_err, err_cnt, err_cnt2}, {1'b1, 3'b100, 8'd0, 2'd0});
    end
    checks++;
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] words [6] = '{11'd0, 11'd2, 11'd6, 11'd14, 11'd16, 11'd0};
    drive(1'b1, 11'd9, 1'b0);
    drive(1'b0, 11'd27, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    if (obs !== exp_bundle()) begin
      errors++;
      $display("[TB] FAIL reset_mid_frame: got %h expected %h", obs, exp_bundle());
    end
    checks++;
    in_grant = 1'b0;
    in_data  = 11'd63;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(i == 1, words[i], 1'b0);
      if (obs !== exp_bundle()) begin
        errors++;
        $display("[TB] FAIL after_reset cycle %0d: got %h expected %h", i, obs, exp_bundle());
      end
      checks++;
      if (i == 4 && {d_valid, d_out, prod_err, range_err} !== {1'b1, 8'd2, 3'b000, 1'b0}) begin
        errors++;
        $display("[TB] FAIL after_reset_result: got %h expected %h",
                 {d_valid, d_out, prod_err, range_err}, {1'b1, 8'd2, 3'b000, 1'b0});
      end
      if (i == 4) checks++;
    end
  endtask

  task automatic test_random();
    logic [10:0] w [4];
    int d;
    int hi;
    for (int f = 0; f < 80; f++) begin
      d  = $urandom_range(0, 255);
      hi = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0;
      w[0] = 11'((hi << 8) | d);
      w[1] = 11'(3 * d);
      w[2] = 11'(7 * d);
      w[3] = 11'(8 * d);
      if ($urandom_range(0, 3) == 0) begin
        w[$urandom_range(1, 3)] ^= 11'(1 << $urandom_range(0, 10));
      end
      for (int i = 0; i < 4; i++) begin
        drive((i == 0) || ($urandom_range(0, 24) == 0), w[i], $urandom_range(0, 19) == 0);
        if (obs !== exp_bundle()) begin
          errors++;
          $display("[TB] FAIL random frame %0d word %0d: got %h expected %h", f, i, obs, exp_bundle());
        end
        checks++;
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        drive(1'b0, 11'($urandom_range(0, 2047)), 1'b0);
        if (obs !== exp_bundle()) begin
          errors++;
          $display("[TB] FAIL random gap frame %0d: got %h expected %h", f, obs, exp_bundle());
        end
        checks++;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_clean_frame();
    test_back_to_back();
    test_prod_and_range();
    test_sync_abort();
    test_saturation();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
